weakbus_arbiter: RTL and testbench

Shares one req/ack memory bus between N_MASTERS requesters, for example the weakcore fetch/load-store port plus a DMA or debug master. Grants are round-robin. The owner's address, write flag and write data are forwarded to the single slave, and the slave's ack and read data are returned to the owner. A per-transaction timeout answers with an error if the slave never acks.

---
 rtl/weakbus_pkg.sv | 25 ++
 rtl/rr_picker.sv | 37 +++
 rtl/weakbus_arbiter.sv | 122 ++++++++++++
 tb/tb_weakbus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weakbus_pkg.sv
// Shared types and constants for the weakbus arbiter and its helpers.
package weakbus_pkg;

   localparam int unsigned BUS_W = 32;
   localparam logic [BUS_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      int unsigned p;
      w = 0;
      p = 1;
      while (p < value) begin
         p = p << 1;
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after index last_i, wrapping.
module rr_picker
   import weakbus_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]        req_i,
   input  logic [clog2(N)-1:0] last_i,
   output logic                gnt_valid_o,
   output logic [clog2(N)-1:0] gnt_idx_o
);

   localparam int unsigned IdxW = clog2(N);

   int               sum;
   logic [IdxW-1:0]  cand;

   // Walk from the farthest offset down so the nearest requester after last_i wins.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      sum         = 0;
      cand        = '0;
      for (int k = int'(N); k >= 1; k--) begin
         sum = int'(last_i) + k;
         if (sum >= int'(N)) begin
            sum = sum - int'(N);
         end
         cand = IdxW'(sum);
         if (req_i[cand]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/weakbus_arbiter.sv
// Round-robin arbiter sharing one req/ack slave bus between N_MASTERS masters,
// with a per-transaction timeout that completes with an error.
module weakbus_arbiter
   import weakbus_pkg::*;
#(
   parameter int unsigned      N_MASTERS = 2,
   parameter int unsigned      TIMEOUT   = 255,
   parameter logic [BUS_W-1:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_MASTERS-1:0]         m_req_i,
   input  logic [N_MASTERS-1:0]         m_wr_i,
   input  logic [BUS_W*N_MASTERS-1:0]   m_addr_i,
   input  logic [BUS_W*N_MASTERS-1:0]   m_out_i,
   output logic [BUS_W-1:0]             m_in_o,
   output logic [N_MASTERS-1:0]         m_ack_o,
   output logic [N_MASTERS-1:0]         m_err_o,
   output logic                         s_req_o,
   output logic                         s_wr_o,
   output logic [BUS_W-1:0]             s_addr_o,
   output logic [BUS_W-1:0]             s_out_o,
   input  logic [BUS_W-1:0]             s_in_i,
   input  logic                         s_ack_i,
   output logic [clog2(N_MASTERS)-1:0]  owner_o
);

   localparam int unsigned IdxW = clog2(N_MASTERS);
   localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [IdxW-1:0] owner_q, owner_d;
   logic [IdxW-1:0] last_q, last_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            gnt_valid;
   logic [IdxW-1:0] gnt_idx;
   logic            timeout;

   logic [BUS_W-1:0] addr_a  [N_MASTERS];
   logic [BUS_W-1:0] wdata_a [N_MASTERS];

   for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
      assign addr_a[g]  = m_addr_i[g*BUS_W +: BUS_W];
      assign wdata_a[g] = m_out_i[g*BUS_W +: BUS_W];
   end

   rr_picker #(
      .N (N_MASTERS)
   ) u_picker (
      .req_i       (m_req_i),
      .last_i      (last_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // TIMEOUT of zero never fires; the counter then just idles at zero.
   assign timeout = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));
   assign owner_o = owner_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= IdxW'(N_MASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt_idx;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (s_ack_i || timeout) begin
               last_d  = owner_q;
               state_d = ST_IDLE;
            end else if (TIMEOUT != 0 && cnt_q != CntW'(TIMEOUT)) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Everything towards masters and slave is zero outside BUSY.
   always_comb begin
      s_req_o  = 1'b0;
      s_wr_o   = 1'b0;
      s_addr_o = '0;
      s_out_o  = '0;
      m_in_o   = '0;
      m_ack_o  = '0;
      m_err_o  = '0;
      if (state_q == ST_BUSY) begin
         s_req_o  = 1'b1;
         s_wr_o   = m_wr_i[owner_q];
         s_addr_o = addr_a[owner_q];
         s_out_o  = wdata_a[owner_q];
         m_in_o   = (timeout && !s_ack_i) ? ERR_DATA : s_in_i;
         if (s_ack_i || timeout) begin
            m_ack_o[owner_q] = 1'b1;
            m_err_o[owner_q] = !s_ack_i;
         end
      end
   end

endmodule

// File: tb/tb_weakbus_arbiter.sv
// Scoreboard bench: tests queue expected grants/completions, a monitor checks them.
module tb_weakbus_arbiter;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic [31:0] owner;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } slv_t;

   typedef struct packed {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [31:0] rdata;
      logic [31:0] cyc;
   } done_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_req_i;
   logic [1:0]  m_wr_i;
   logic [63:0] m_addr_i;
   logic [63:0] m_out_i;
   logic [31:0] m_in_o;
   logic [1:0]  m_ack_o;
   logic [1:0]  m_err_o;
   logic        s_req_o;
   logic        s_wr_o;
   logic [31:0] s_addr_o;
   logic [31:0] s_out_o;
   logic [31:0] s_in_i;
   logic        s_ack_i;
   logic [0:0]  owner_o;

   int          n_checks = 0;
   int          n_fail   = 0;

   int          ack_delay   = 1;
   logic [31:0] slave_rdata = '0;
   logic        spur_ack    = 1'b0;

   xfer_t mq0[$];
   xfer_t mq1[$];
   slv_t  exp_slv[$];
   done_t exp_done[$];

   always #5 clk = ~clk;

   weakbus_arbiter #(
      .N_MASTERS (2),
      .TIMEOUT   (4),
      .ERR_DATA  (32'hDEADBEEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_req_i  (m_req_i),
      .m_wr_i   (m_wr_i),
      .m_addr_i (m_addr_i),
      .m_out_i  (m_out_i),
      .m_in_o   (m_in_o),
      .m_ack_o  (m_ack_o),
      .m_err_o  (m_err_o),
      .s_req_o  (s_req_o),
      .s_wr_o   (s_wr_o),
      .s_addr_o (s_addr_o),
      .s_out_o  (s_out_o),
      .s_in_i   (s_in_i),
      .s_ack_i  (s_ack_i),
      .owner_o  (owner_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_grant(input int owner, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
      exp_slv.push_back('{owner: owner, wr: wr, addr: addr, wdata: wdata});
   endtask

   task automatic exp_cpl(input int idx, input logic err, input logic [31:0] rdata,
                          input int cyc);
      logic [1:0] v;
      v = 2'b01 << idx;
      exp_done.push_back('{ack: v, err: err ? v : 2'b00, rdata: rdata, cyc: cyc});
   endtask

   // Master agents: present the head of each queue until the monitor sees its ack.
   initial begin
      forever begin
         m_req_i  = {mq1.size() != 0, mq0.size() != 0};
         m_wr_i   = '0;
         m_addr_i = '0;
         m_out_i  = '0;
         if (mq0.size() != 0) begin
            m_wr_i[0]        = mq0[0].wr;
            m_addr_i[31:0]   = mq0[0].addr;
            m_out_i[31:0]    = mq0[0].wdata;
         end
         if (mq1.size() != 0) begin
            m_wr_i[1]        = mq1[0].wr;
            m_addr_i[63:32]  = mq1[0].addr;
            m_out_i[63:32]   = mq1[0].wdata;
         end
         @(posedge clk);
         #1;
      end
   end

   // Slave: acks in BUSY cycle ack_delay (0 = never); spur_ack forces s_ack.
   initial begin
      int bcnt;
      bcnt    = 0;
      s_ack_i = 1'b0;
      s_in_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (s_req_o) bcnt++;
         else bcnt = 0;
         s_ack_i = spur_ack || (s_req_o && ack_delay != 0 && bcnt == ack_delay);
         s_in_i  = slave_rdata;
      end
   end

   // Monitor: checks each new grant and each completion against the queues.
   initial begin
      int    busy_len;
      slv_t  es;
      done_t ed;
      busy_len = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy_len = 0;
         end else begin
            if (s_req_o) busy_len++;
            else busy_len = 0;
            if (busy_len == 1) begin
               if (exp_slv.size() == 0) begin
                  chk("unexpected_grant", {31'b0, s_req_o}, 32'd0);
               end else begin
                  es = exp_slv.pop_front();
                  chk("grant_owner", {31'b0, owner_o}, es.owner);
                  chk("grant_wr", {31'b0, s_wr_o}, {31'b0, es.wr});
                  chk("grant_addr", s_addr_o, es.addr);
                  chk("grant_wdata", s_out_o, es.wdata);
               end
            end
            if (m_ack_o != 2'b00) begin
               if (exp_done.size() == 0) begin
                  chk("unexpected_ack", {30'b0, m_ack_o}, 32'd0);
               end else begin
                  ed = exp_done.pop_front();
                  chk("ack_vec", {30'b0, m_ack_o}, {30'b0, ed.ack});
                  chk("err_vec", {30'b0, m_err_o}, {30'b0, ed.err});
                  chk("rdata", m_in_o, ed.rdata);
                  chk("ack_cycle", busy_len, ed.cyc);
               end
               if (m_ack_o[0] && mq0.size() != 0) void'(mq0.pop_front());
               if (m_ack_o[1] && mq1.size() != 0) void'(mq1.pop_front());
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((mq0.size() + mq1.size() + exp_slv.size() + exp_done.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timed out with %0d grants and %0d completions outstanding",
                  name, exp_slv.size(), exp_done.size());
         mq0.delete();
         mq1.delete();
         exp_slv.delete();
         exp_done.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mq0.delete();
      mq1.delete();
      exp_slv.delete();
      exp_done.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_s_req"}, {31'b0, s_req_o}, 32'd0);
      chk({tag, "_s_wr"}, {31'b0, s_wr_o}, 32'd0);
      chk({tag, "_s_addr"}, s_addr_o, 32'd0);
      chk({tag, "_s_out"}, s_out_o, 32'd0);
      chk({tag, "_m_ack"}, {30'b0, m_ack_o}, 32'd0);
      chk({tag, "_m_err"}, {30'b0, m_err_o}, 32'd0);
      chk({tag, "_m_in"}, m_in_o, 32'd0);
      chk({tag, "_owner"}, {31'b0, owner_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0;
      @(negedge clk);
      do_reset();
      check_idle("reset");

      // Single read by master 0, slave acks in the third BUSY cycle.
      ack_delay   = 3;
      slave_rdata = 32'h12345678;
      mq0.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'h0});
      exp_grant(0, 1'b0, 32'h100, 32'h0);
      exp_cpl(0, 1'b0, 32'h12345678, 3);
      wait_drain("single_read", 40);

      // Both request together after reset: master 0 first, then master 1's write.
      do_reset();
      ack_delay   = 1;
      slave_rdata = 32'h11110000;
      mq0.push_back('{wr: 1'b0, addr: 32'h10, wdata: 32'h0});
      mq1.push_back('{wr: 1'b1, addr: 32'h20, wdata: 32'hA5A5A5A5});
      exp_grant(0, 1'b0, 32'h10, 32'h0);
      exp_cpl(0, 1'b0, 32'h11110000, 1);
      exp_grant(1, 1'b1, 32'h20, 32'hA5A5A5A5);
      exp_cpl(1, 1'b0, 32'h11110000, 1);
      wait_drain("both_req", 40);

      // Eight back-to-back transfers alternate 0,1,0,1,...
      slave_rdata = 32'h0000C0DE;
      for (int k = 0; k < 4; k++) begin
         mq0.push_back('{wr: 1'b0, addr: 32'h1000 + 32'(4*k), wdata: 32'h0});
         mq1.push_back('{wr: 1'b1, addr: 32'h2000 + 32'(4*k), wdata: 32'h50 + 32'(k)});
         exp_grant(0, 1'b0, 32'h1000 + 32'(4*k), 32'h0);
         exp_cpl(0, 1'b0, 32'h0000C0DE, 1);
         exp_grant(1, 1'b1, 32'h2000 + 32'(4*k), 32'h50 + 32'(k));
         exp_cpl(1, 1'b0, 32'h0000C0DE, 1);
      end
      wait_drain("round_robin", 80);

      // Slave never acks: error completion after 4 BUSY cycles, then master 1 served.
      ack_delay   = 0;
      slave_rdata = 32'h77777777;
      mq0.push_back('{wr: 1'b0, addr: 32'h300, wdata: 32'h0});
      exp_grant(0, 1'b0, 32'h300, 32'h0);
      exp_cpl(0, 1'b1, 32'hDEADBEEF, 5);
      wait_drain("timeout", 40);
      ack_delay = 1;
      mq1.push_back('{wr: 1'b0, addr: 32'h400, wdata: 32'h0});
      exp_grant(1, 1'b0, 32'h400, 32'h0);
      exp_cpl(1, 1'b0, 32'h77777777, 1);
      wait_drain("after_timeout", 40);

      // Spurious ack while idle must not complete anything.
      spur_ack = 1'b1;
      @(negedge clk);
      chk("spur_idle_ack", {30'b0, m_ack_o}, 32'd0);
      spur_ack = 1'b0;
      @(negedge clk);

      // Ack in the same cycle the timeout fires: normal completion, no error.
      ack_delay   = 5;
      slave_rdata = 32'h5A5A0001;
      mq1.push_back('{wr: 1'b0, addr: 32'h500, wdata: 32'h0});
      exp_grant(1, 1'b0, 32'h500, 32'h0);
      exp_cpl(1, 1'b0, 32'h5A5A0001, 5);
      wait_drain("ack_vs_timeout", 40);
      ack_delay = 2;
      mq0.push_back('{wr: 1'b1, addr: 32'h600, wdata: 32'hCAFEF00D});
      exp_grant(0, 1'b1, 32'h600, 32'hCAFEF00D);
      exp_cpl(0, 1'b0, 32'h5A5A0001, 2);
      wait_drain("m0_last", 40);

      // Reset in the middle of a transfer, then a late ack and a fresh contest.
      ack_delay = 0;
      mq0.push_back('{wr: 1'b0, addr: 32'h700, wdata: 32'h0});
      exp_grant(0, 1'b0, 32'h700, 32'h0);
      n = 0;
      while (!s_req_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midbusy_started", {31'b0, s_req_o}, 32'd1);
      @(negedge clk);
      do_reset();
      spur_ack = 1'b1;
      @(negedge clk);
      chk("post_reset_ack", {30'b0, m_ack_o}, 32'd0);
      chk("post_reset_sreq", {31'b0, s_req_o}, 32'd0);
      chk("post_reset_owner", {31'b0, owner_o}, 32'd0);
      spur_ack  = 1'b0;
      ack_delay = 1;
      slave_rdata = 32'h00ABCDEF;
      @(negedge clk);
      mq0.push_back('{wr: 1'b0, addr: 32'h800, wdata: 32'h0});
      mq1.push_back('{wr: 1'b0, addr: 32'h900, wdata: 32'h0});
      exp_grant(0, 1'b0, 32'h800, 32'h0);
      exp_cpl(0, 1'b0, 32'h00ABCDEF, 1);
      exp_grant(1, 1'b0, 32'h900, 32'h0);
      exp_cpl(1, 1'b0, 32'h00ABCDEF, 1);
      wait_drain("post_reset_rr", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
